ram_2r1w_ctrl: RTL and testbench

- Front-end controller for the banked 2R1W RAM (two data banks plus XOR bank, 1 write and 2 read ports per cycle).
- After reset, or on a clear command, sweeps every address with a fill value so the XOR bank is consistent with the data banks.
- In service mode, gives one write client and two read clients valid/ready access.
- Stalls read port 2 when it would hit the one-cycle XOR-bank write-back window.

---
 rtl/ram2r1w_pkg.sv | 14 +
 rtl/ram_2r1w_hazard.sv | 39 +++
 rtl/ram_2r1w_ctrl.sv | 114 +++++++++++
 tb/tb_ram_2r1w_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2r1w_pkg.sv
// Shared types and helpers for the banked 2R1W RAM front-end controller.
package ram2r1w_pkg;

   localparam int AW_DEF = 11;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {FILL, DRAIN, SERVE} state_e;

   // Index within a data bank: the address with its bank-select MSB stripped.
   function automatic logic [31:0] bank_idx(input logic [31:0] addr, input int aw);
      return addr & ((32'd1 << (aw - 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/ram_2r1w_hazard.sv
// Tracks last cycle's RAM write and stalls read port 2 when it would collide
// with the XOR-bank write-back of that write.
module ram_2r1w_hazard
   import ram2r1w_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic          r2_valid_i,
   input  logic [AW-1:0] r2_addr_i,
   output logic          stall_o
);

   logic          pend_v_q, pend_v_d;
   logic [AW-2:0] pend_a_q, pend_a_d;
   logic [AW-2:0] r2_idx;

   always_comb begin
      pend_v_d = we_i;
      pend_a_d = (AW-1)'(bank_idx(32'(waddr_i), AW));
      r2_idx   = (AW-1)'(bank_idx(32'(r2_addr_i), AW));
      // Either bank can collide: the XOR bank is shared, so only the index matters.
      stall_o  = pend_v_q & r2_valid_i & (r2_idx == pend_a_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q <= 1'b0;
         pend_a_q <= '0;
      end else begin
         pend_v_q <= pend_v_d;
         pend_a_q <= pend_a_d;
      end
   end

endmodule

// File: rtl/ram_2r1w_ctrl.sv
// Front-end controller for the banked 2R1W RAM: fill sweep after reset/clear,
// then valid/ready service of one write and two read clients.
module ram_2r1w_ctrl
   import ram2r1w_pkg::*;
#(
   parameter int              AW       = AW_DEF,
   parameter int              DW       = DW_DEF,
   parameter logic [DW-1:0]   INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          init_done,
   input  logic          w_valid,
   input  logic [AW-1:0] w_addr,
   input  logic [DW-1:0] w_data,
   output logic          w_ready,
   input  logic          r1_valid,
   input  logic [AW-1:0] r1_addr,
   output logic          r1_ready,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   input  logic          r2_valid,
   input  logic [AW-1:0] r2_addr,
   output logic          r2_ready,
   output logic          r2_rvalid,
   output logic [DW-1:0] r2_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addrw,
   output logic [DW-1:0] mem_dinw,
   output logic [AW-1:0] mem_addr1,
   output logic [AW-1:0] mem_addr2,
   input  logic [DW-1:0] mem_dout1,
   input  logic [DW-1:0] mem_dout2
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          r1_rvalid_q, r1_rvalid_d;
   logic          r2_rvalid_q, r2_rvalid_d;
   logic          r2_stall;
   logic          serve;

   ram_2r1w_hazard #(.AW(AW)) u_hazard (
      .clk        (clk),
      .rst        (rst),
      .we_i       (mem_we),
      .waddr_i    (mem_addrw),
      .r2_valid_i (r2_valid),
      .r2_addr_i  (r2_addr),
      .stall_o    (r2_stall)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      serve     = 1'b0;
      mem_we    = 1'b0;
      mem_addrw = w_addr;
      mem_dinw  = w_data;
      unique case (state_q)
         FILL: begin
            mem_we    = 1'b1;
            mem_addrw = cnt_q;
            mem_dinw  = INIT_VAL;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = DRAIN;
         end
         // One idle write cycle lets the delayed XOR write of the last fill word land.
         DRAIN: state_d = SERVE;
         SERVE: begin
            serve  = 1'b1;
            mem_we = w_valid;
            if (clr_req) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase

      w_ready     = serve;
      r1_ready    = serve;
      r2_ready    = serve & ~r2_stall;
      init_done   = serve;
      r1_rvalid_d = r1_valid & r1_ready;
      r2_rvalid_d = r2_valid & r2_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         r1_rvalid_q <= 1'b0;
         r2_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r1_rvalid_q <= r1_rvalid_d;
         r2_rvalid_q <= r2_rvalid_d;
      end
   end

   assign mem_addr1 = r1_addr;
   assign mem_addr2 = r2_addr;
   assign r1_rvalid = r1_rvalid_q;
   assign r2_rvalid = r2_rvalid_q;
   assign r1_rdata  = mem_dout1;
   assign r2_rdata  = mem_dout2;

endmodule

// File: tb/tb_ram_2r1w_ctrl.sv
// Self-checking bench for ram_2r1w_ctrl with a small 2R1W RAM model and a
// reference memory feeding per-port expected-read-data queues.
module tb_ram_2r1w_ctrl;

   localparam int            AW    = 4;
   localparam int            DW    = 32;
   localparam int            NADDR = 1 << AW;
   localparam logic [DW-1:0] INIT  = 32'hC0DE_0001;

   logic          clk = 1'b0;
   logic          rst, clrReq, initDone;
   logic          wValid, wReady;
   logic [AW-1:0] wAddr;
   logic [DW-1:0] wData;
   logic          r1Valid, r1Ready, r1Rvalid;
   logic [AW-1:0] r1Addr;
   logic [DW-1:0] r1Rdata;
   logic          r2Valid, r2Ready, r2Rvalid;
   logic [AW-1:0] r2Addr;
   logic [DW-1:0] r2Rdata;
   logic          memWe;
   logic [AW-1:0] memAddrw, memAddr1, memAddr2;
   logic [DW-1:0] memDinw, memDout1, memDout2;

   logic [DW-1:0] ramMem [NADDR];
   logic [DW-1:0] refMem [NADDR];
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] q2 [$];
   int            testsRun = 0;
   int            testsFailed = 0;

   always #5 clk = ~clk;

   ram_2r1w_ctrl #(.AW(AW), .DW(DW), .INIT_VAL(INIT)) dut (
      .clk(clk), .rst(rst), .clr_req(clrReq), .init_done(initDone),
      .w_valid(wValid), .w_addr(wAddr), .w_data(wData), .w_ready(wReady),
      .r1_valid(r1Valid), .r1_addr(r1Addr), .r1_ready(r1Ready),
      .r1_rvalid(r1Rvalid), .r1_rdata(r1Rdata),
      .r2_valid(r2Valid), .r2_addr(r2Addr), .r2_ready(r2Ready),
      .r2_rvalid(r2Rvalid), .r2_rdata(r2Rdata),
      .mem_we(memWe), .mem_addrw(memAddrw), .mem_dinw(memDinw),
      .mem_addr1(memAddr1), .mem_addr2(memAddr2),
      .mem_dout1(memDout1), .mem_dout2(memDout2)
   );

   // Synchronous-read RAM model: a read and write to one address in the same cycle returns old data.
   always @(posedge clk) begin
      memDout1 <= ramMem[memAddr1];
      memDout2 <= ramMem[memAddr2];
      if (memWe) ramMem[memAddrw] <= memDinw;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      clrReq = 1'b0; wValid = 1'b0; wAddr = '0; wData = '0;
      r1Valid = 1'b0; r1Addr = '0; r2Valid = 1'b0; r2Addr = '0;
   endtask

   task automatic test_reset();
      clearInputs();
      rst = 1'b1; wValid = 1'b1; wAddr = 4'h5; r1Valid = 1'b1; r2Valid = 1'b1; clrReq = 1'b1;
      tick();
      tick();
      testsRun++;
      if ({initDone, wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid} !== 6'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {initDone, wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid});
      end
      testsRun++;
      if (memWe !== 1'b1 || memAddrw !== 4'h0 || memDinw !== INIT) begin
         testsFailed++;
         $display("[TB] FAIL reset_fill: got we=%b addr=%h din=%h expected we=1 addr=0 din=%h",
                  memWe, memAddrw, memDinw, INIT);
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] exp;
      // Client requests and clr_req stay asserted throughout the sweep and must be ignored.
      rst = 1'b0; wData = 32'hDEAD_BEEF;
      for (int i = 0; i < NADDR; i++) begin
         #1;
         testsRun++;
         if (memWe !== 1'b1 || memAddrw !== AW'(i) || memDinw !== INIT ||
             {wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid, initDone} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL fill_cycle%0d: got we=%b addr=%h din=%h flags=%b expected we=1 addr=%h din=%h flags=000000",
                     i, memWe, memAddrw, memDinw, {wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid, initDone},
                     AW'(i), INIT);
         end
         tick();
      end
      #1;
      testsRun++;
      if (memWe !== 1'b0 || {wReady, r1Ready, r2Ready, initDone} !== 4'b0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got we=%b flags=%b expected we=0 flags=0000",
                  memWe, {wReady, r1Ready, r2Ready, initDone});
      end
      tick();
      clearInputs();
      for (int i = 0; i < NADDR; i++) refMem[i] = INIT;
      #1;
      testsRun++;
      if ({initDone, wReady, r1Ready, r2Ready, r1Rvalid} !== 5'b11110) begin
         testsFailed++;
         $display("[TB] FAIL first_serve: got %b expected 11110",
                  {initDone, wReady, r1Ready, r2Ready, r1Rvalid});
      end
      r1Valid = 1'b1; r1Addr = 4'h9;
      q1.push_back(refMem[9]);
      tick();
      clearInputs();
      testsRun++;
      if (r1Rvalid !== 1'b1 || q1.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL fill_read_rvalid: got %b expected 1", r1Rvalid);
      end else begin
         exp = q1.pop_front();
         testsRun++;
         if (r1Rdata !== exp) begin
            testsFailed++;
            $display("[TB] FAIL fill_read_data: got %h expected %h", r1Rdata, exp);
         end
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] exp;
      wValid = 1'b1; wAddr = 4'h3; wData = 32'h0000_A5A5;
      #1;
      testsRun++;
      if (wReady !== 1'b1 || memWe !== 1'b1 || memAddrw !== 4'h3 || memDinw !== 32'h0000_A5A5) begin
         testsFailed++;
         $display("[TB] FAIL write_path: got rdy=%b we=%b addr=%h din=%h expected 1 1 3 0000a5a5",
                  wReady, memWe, memAddrw, memDinw);
      end
      tick();
      refMem[3] = 32'h0000_A5A5;
      clearInputs();
      r1Valid = 1'b1; r1Addr = 4'h3;
      q1.push_back(refMem[3]);
      tick();
      clearInputs();
      testsRun++;
      if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b0 || q1.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL wr_rd_rvalid: got r1=%b r2=%b expected r1=1 r2=0", r1Rvalid, r2Rvalid);
      end else begin
         exp = q1.pop_front();
         testsRun++;
         if (r1Rdata !== exp) begin
            testsFailed++;
            $display("[TB] FAIL wr_rd_data: got %h expected %h", r1Rdata, exp);
         end
      end
   endtask

   task automatic test_xor_hazard();
      logic [DW-1:0] exp;
      wValid = 1'b1; wAddr = 4'hB; wData = 32'h0000_1234;
      tick();
      refMem[11] = 32'h0000_1234;
      clearInputs();
      r2Valid = 1'b1; r2Addr = 4'h3; r1Valid = 1'b1; r1Addr = 4'hB;
      #1;
      testsRun++;
      if (r2Ready !== 1'b0 || r1Ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL hazard_stall: got r2rdy=%b r1rdy=%b expected r2rdy=0 r1rdy=1", r2Ready, r1Ready);
      end
      q1.push_back(refMem[11]);
      tick();
      r1Valid = 1'b0;
      testsRun++;
      if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b0 || q1.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL hazard_r1_rvalid: got r1=%b r2=%b expected r1=1 r2=0", r1Rvalid, r2Rvalid);
      end else begin
         exp = q1.pop_front();
         testsRun++;
         if (r1Rdata !== exp) begin
            testsFailed++;
            $display("[TB] FAIL hazard_r1_data: got %h expected %h", r1Rdata, exp);
         end
      end
      // The held request must be taken within a short budget once the write-back window passes.
      begin
         int waited = 0;
         #1;
         while (r2Ready !== 1'b1 && waited < 4) begin
            tick();
            waited++;
         end
         testsRun++;
         if (waited != 0) begin
            testsFailed++;
            $display("[TB] FAIL hazard_release: got %0d extra stall cycles expected 0", waited);
         end
      end
      q2.push_back(refMem[3]);
      tick();
      clearInputs();
      testsRun++;
      if (r2Rvalid !== 1'b1 || r1Rvalid !== 1'b0 || q2.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL hazard_r2_rvalid: got r2=%b r1=%b expected r2=1 r1=0", r2Rvalid, r1Rvalid);
      end else begin
         exp = q2.pop_front();
         testsRun++;
         if (r2Rdata !== exp) begin
            testsFailed++;
            $display("[TB] FAIL hazard_r2_data: got %h expected %h", r2Rdata, exp);
         end
      end
   endtask

   task automatic test_dual_read();
      logic [DW-1:0] exp1, exp2;
      wValid = 1'b1; wAddr = 4'h5; wData = 32'h11;
      tick();
      refMem[5] = 32'h11;
      wAddr = 4'hD; wData = 32'h22;
      tick();
      refMem[13] = 32'h22;
      clearInputs();
      tick();
      r1Valid = 1'b1; r1Addr = 4'h5; r2Valid = 1'b1; r2Addr = 4'hD;
      #1;
      testsRun++;
      if (r1Ready !== 1'b1 || r2Ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL dual_ready: got r1=%b r2=%b expected 1 1", r1Ready, r2Ready);
      end
      q1.push_back(refMem[5]);
      q2.push_back(refMem[13]);
      tick();
      clearInputs();
      testsRun++;
      if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b1 || q1.size() == 0 || q2.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL dual_rvalid: got r1=%b r2=%b expected 1 1", r1Rvalid, r2Rvalid);
      end else begin
         exp1 = q1.pop_front();
         exp2 = q2.pop_front();
         testsRun++;
         if (r1Rdata !== exp1 || r2Rdata !== exp2) begin
            testsFailed++;
            $display("[TB] FAIL dual_data: got %h %h expected %h %h", r1Rdata, r2Rdata, exp1, exp2);
         end
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] exp1, exp2;
      wValid = 1'b1; wAddr = 4'h7; wData = 32'h0000_BEEF;
      r1Valid = 1'b1; r1Addr = 4'h7; r2Valid = 1'b1; r2Addr = 4'h7;
      #1;
      testsRun++;
      if (r2Ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL collide_ready: got %b expected 1", r2Ready);
      end
      q1.push_back(refMem[7]);
      q2.push_back(refMem[7]);
      tick();
      refMem[7] = 32'h0000_BEEF;
      wValid = 1'b0; r2Addr = 4'h4;
      testsRun++;
      if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b1 || q1.size() == 0 || q2.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL collide_rvalid: got r1=%b r2=%b expected 1 1", r1Rvalid, r2Rvalid);
      end else begin
         exp1 = q1.pop_front();
         exp2 = q2.pop_front();
         testsRun++;
         if (r1Rdata !== exp1 || r2Rdata !== exp2) begin
            testsFailed++;
            $display("[TB] FAIL collide_old_data: got %h %h expected %h %h", r1Rdata, r2Rdata, exp1, exp2);
         end
      end
      #1;
      testsRun++;
      if (r2Ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL other_idx_ready: got %b expected 1", r2Ready);
      end
      q1.push_back(refMem[7]);
      q2.push_back(refMem[4]);
      tick();
      clearInputs();
      testsRun++;
      if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b1 || q1.size() == 0 || q2.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL after_write_rvalid: got r1=%b r2=%b expected 1 1", r1Rvalid, r2Rvalid);
      end else begin
         exp1 = q1.pop_front();
         exp2 = q2.pop_front();
         testsRun++;
         if (r1Rdata !== exp1 || r2Rdata !== exp2) begin
            testsFailed++;
            $display("[TB] FAIL after_write_data: got %h %h expected %h %h", r1Rdata, r2Rdata, exp1, exp2);
         end
      end
   endtask

   task automatic test_clear();
      clrReq = 1'b1;
      tick();
      clearInputs();
      r1Valid = 1'b1; r1Addr = 4'h3; r2Valid = 1'b1; r2Addr = 4'h2; wValid = 1'b1; wData = 32'hBAD0_0BAD;
      for (int k = 0; k <= NADDR; k++) begin
         #1;
         testsRun++;
         if ({initDone, wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid} !== 6'b0 ||
             memWe !== (k < NADDR)) begin
            testsFailed++;
            $display("[TB] FAIL clear_cycle%0d: got flags=%b we=%b expected flags=000000 we=%b",
                     k, {initDone, wReady, r1Ready, r2Ready, r1Rvalid, r2Rvalid}, memWe, k < NADDR);
         end
         tick();
      end
      clearInputs();
      for (int i = 0; i < NADDR; i++) refMem[i] = INIT;
      testsRun++;
      if (initDone !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL clear_done: got %b expected 1", initDone);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp1, exp2;
      for (int i = 0; i <= NADDR; i++) begin
         if (i > 0) begin
            testsRun++;
            if (r1Rvalid !== 1'b1 || r2Rvalid !== 1'b1 || q1.size() == 0 || q2.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL b2b_rvalid%0d: got r1=%b r2=%b expected 1 1", i - 1, r1Rvalid, r2Rvalid);
            end else begin
               exp1 = q1.pop_front();
               exp2 = q2.pop_front();
               testsRun++;
               if (r1Rdata !== exp1 || r2Rdata !== exp2) begin
                  testsFailed++;
                  $display("[TB] FAIL b2b_data%0d: got %h %h expected %h %h", i - 1, r1Rdata, r2Rdata, exp1, exp2);
               end
            end
         end
         if (i < NADDR) begin
            r1Valid = 1'b1; r1Addr = AW'(i); r2Valid = 1'b1; r2Addr = AW'(NADDR - 1 - i);
            q1.push_back(refMem[i]);
            q2.push_back(refMem[NADDR - 1 - i]);
         end else begin
            clearInputs();
         end
         tick();
      end
   endtask

   task automatic test_rst_mid();
      clrReq = 1'b1;
      tick();
      clearInputs();
      for (int k = 0; k < 7; k++) tick();
      testsRun++;
      if (memAddrw !== 4'h7 || memWe !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL sweep_at7: got addr=%h we=%b expected 7 1", memAddrw, memWe);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      testsRun++;
      if (memAddrw !== 4'h0 || memWe !== 1'b1 || {initDone, wReady, r1Ready, r2Ready} !== 4'b0) begin
         testsFailed++;
         $display("[TB] FAIL sweep_restart: got addr=%h we=%b flags=%b expected 0 1 0000",
                  memAddrw, memWe, {initDone, wReady, r1Ready, r2Ready});
      end
      for (int k = 0; k <= NADDR; k++) tick();
      wValid = 1'b1; wAddr = 4'h2; wData = 32'h5555_AAAA;
      r1Valid = 1'b1; r1Addr = 4'h2; r2Valid = 1'b1; r2Addr = 4'h6;
      rst = 1'b1;
      #1;
      testsRun++;
      if (initDone !== 1'b1 || r1Ready !== 1'b1 || r2Ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL inflight_issue: got done=%b r1=%b r2=%b expected 1 1 1", initDone, r1Ready, r2Ready);
      end
      tick();
      rst = 1'b0;
      clearInputs();
      for (int k = 0; k < 2; k++) begin
         testsRun++;
         if ({r1Rvalid, r2Rvalid, initDone, wReady, r1Ready, r2Ready} !== 6'b0 ||
             memWe !== 1'b1 || memAddrw !== AW'(k)) begin
            testsFailed++;
            $display("[TB] FAIL inflight_drop%0d: got flags=%b we=%b addr=%h expected 000000 1 %h",
                     k, {r1Rvalid, r2Rvalid, initDone, wReady, r1Ready, r2Ready}, memWe, memAddrw, AW'(k));
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_xor_hazard();
      test_dual_read();
      test_collision();
      test_clear();
      test_back_to_back();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
